// File: rtl/seg_display_scheduler.sv
// AHB-Lite master that pushes a coherent frac/int/mode triple to the seven-segment
// display slave on every refresh tick, mode change or displayed-value update.
module seg_display_scheduler #(
    parameter logic [31:0] BASE_ADDR      = 32'hA000_0000,
    parameter int unsigned REFRESH_CYCLES = 1024
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        ModeNext,
    input  logic        Setting,
    input  logic        SetUpdate,
    input  logic [11:0] SetInt,
    input  logic [3:0]  ChUpdate,
    input  logic [31:0] ChFrac,
    input  logic [47:0] ChInt,
    input  logic        HREADY,
    output logic [31:0] HADDR,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic [1:0]  Mode,
    output logic        Busy
);

    localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    localparam logic [31:0] OFS_INT  = 32'd4;
    localparam logic [31:0] OFS_MODE = 32'd8;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_A_FRAC = 3'd1;
    localparam logic [2:0] S_A_INT  = 3'd2;
    localparam logic [2:0] S_A_MODE = 3'd3;
    localparam logic [2:0] S_D_MODE = 3'd4;

    logic [2:0]       state_q,     state_d;
    logic [1:0]       mode_q,      mode_d;
    logic             setting_q;
    logic             pending_q,   pending_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [7:0]       snap_frac_q, snap_frac_d;
    logic [11:0]      snap_int_q,  snap_int_d;
    logic [3:0]       snap_code_q, snap_code_d;
    logic [31:0]      haddr_q,     haddr_d;
    logic [31:0]      hwdata_q,    hwdata_d;
    logic             hwrite_q,    hwrite_d;
    logic [1:0]       htrans_q,    htrans_d;
    logic             busy_q,      busy_d;

    logic             mode_adv;
    logic             refresh;
    logic             trig;
    logic             launch;
    logic [7:0]       new_frac;
    logic [11:0]      new_int;
    logic [3:0]       new_code;

    logic [7:0]       ch_frac [4];
    logic [11:0]      ch_int  [4];

    for (genvar i = 0; i < 4; i++) begin : g_ch
        assign ch_frac[i] = ChFrac[8*i +: 8];
        assign ch_int[i]  = ChInt[12*i +: 12];
    end

    // Trigger sources, mode advance and free-running refresh counter
    always_comb begin
        mode_adv = ModeNext & ~Setting;
        mode_d   = mode_adv ? mode_q + 2'd1 : mode_q;
        refresh  = (cnt_q == CNT_LAST);
        cnt_d    = refresh ? '0 : cnt_q + CNT_W'(1);
        trig     = mode_adv
                 | (Setting ^ setting_q)
                 | (~Setting & ChUpdate[mode_q])
                 | (Setting & SetUpdate)
                 | refresh;
    end

    // Snapshot source uses the post-ModeNext channel so a mode change shows its own data
    always_comb begin
        if (Setting) begin
            new_frac = 8'h00;
            new_int  = SetInt;
            new_code = 4'hE;
        end else begin
            new_frac = ch_frac[mode_d];
            new_int  = ch_int[mode_d];
            new_code = 4'hA + 4'(mode_d);
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        snap_frac_d = snap_frac_q;
        snap_int_d  = snap_int_q;
        snap_code_d = snap_code_q;
        haddr_d     = haddr_q;
        hwdata_d    = hwdata_q;
        hwrite_d    = hwrite_q;
        htrans_d    = htrans_q;
        busy_d      = busy_q;
        launch      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (trig || pending_q) begin
                    launch    = 1'b1;
                    pending_d = 1'b0;
                end
            end
            S_A_FRAC: begin
                if (trig) pending_d = 1'b1;
                if (HREADY) begin
                    state_d  = S_A_INT;
                    haddr_d  = BASE_ADDR + OFS_INT;
                    hwdata_d = {24'b0, snap_frac_q};
                end
            end
            S_A_INT: begin
                if (trig) pending_d = 1'b1;
                if (HREADY) begin
                    state_d  = S_A_MODE;
                    haddr_d  = BASE_ADDR + OFS_MODE;
                    hwdata_d = {20'b0, snap_int_q};
                end
            end
            S_A_MODE: begin
                if (trig) pending_d = 1'b1;
                if (HREADY) begin
                    state_d  = S_D_MODE;
                    htrans_d = HTRANS_IDLE;
                    hwrite_d = 1'b0;
                    hwdata_d = {28'b0, snap_code_q};
                end
            end
            S_D_MODE: begin
                if (trig) pending_d = 1'b1;
                if (HREADY) begin
                    // A trigger landing on the exit edge stays pending for one more burst
                    if (pending_q) begin
                        launch    = 1'b1;
                        pending_d = trig;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                htrans_d = HTRANS_IDLE;
                hwrite_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase

        if (launch) begin
            state_d     = S_A_FRAC;
            snap_frac_d = new_frac;
            snap_int_d  = new_int;
            snap_code_d = new_code;
            haddr_d     = BASE_ADDR;
            htrans_d    = HTRANS_NONSEQ;
            hwrite_d    = 1'b1;
            busy_d      = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'd0;
            setting_q   <= 1'b0;
            pending_q   <= 1'b0;
            cnt_q       <= '0;
            snap_frac_q <= 8'h00;
            snap_int_q  <= 12'h000;
            snap_code_q <= 4'h0;
            haddr_q     <= 32'h0;
            hwdata_q    <= 32'h0;
            hwrite_q    <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            setting_q   <= Setting;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            snap_frac_q <= snap_frac_d;
            snap_int_q  <= snap_int_d;
            snap_code_q <= snap_code_d;
            haddr_q     <= haddr_d;
            hwdata_q    <= hwdata_d;
            hwrite_q    <= hwrite_d;
            htrans_q    <= htrans_d;
            busy_q      <= busy_d;
        end
    end

    assign HADDR  = haddr_q;
    assign HWDATA = hwdata_q;
    assign HWRITE = hwrite_q;
    assign HTRANS = htrans_q;
    assign HSIZE  = 3'b010;
    assign Mode   = mode_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler: directed bursts, a mode vector table and a random
// phase checked against a transfer-level reference model and an AHB write monitor.
`timescale 1ns/1ps
module tb_seg_display_scheduler;

    localparam int unsigned R    = 128;
    localparam logic [31:0] BASE = 32'hA000_0000;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        ModeNext = 1'b0;
    logic        Setting = 1'b0;
    logic        SetUpdate = 1'b0;
    logic [11:0] SetInt = 12'h000;
    logic [3:0]  ChUpdate = 4'h0;
    logic [31:0] ChFrac = 32'h0;
    logic [47:0] ChInt = 48'h0;
    logic        HREADY = 1'b1;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [1:0]  Mode;
    logic        Busy;

    seg_display_scheduler #(.BASE_ADDR(BASE), .REFRESH_CYCLES(R)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .ModeNext(ModeNext), .Setting(Setting),
        .SetUpdate(SetUpdate), .SetInt(SetInt), .ChUpdate(ChUpdate), .ChFrac(ChFrac),
        .ChInt(ChInt), .HREADY(HREADY), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .Mode(Mode), .Busy(Busy)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int failures = 0;

    function automatic void check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    wr_t exp_q[$];

    // Reference model: one burst = 4 HREADY-qualified edges carrying three writes
    logic [1:0] m_mode = 2'd0;
    int         m_beats = 0;
    bit         m_pending = 1'b0;
    logic       m_prev_set = 1'b0;
    int         m_tick = 0;
    bit         adv, trig, start;
    logic [1:0] nm;
    logic [7:0] e_frac;
    logic [11:0] e_int;
    logic [3:0] e_code;

    initial forever begin
        @(posedge HCLK or negedge HRESETn);
        if (!HRESETn) begin
            m_mode = 2'd0; m_beats = 0; m_pending = 1'b0; m_prev_set = 1'b0; m_tick = 0;
            exp_q.delete();
        end else begin
            adv  = ModeNext && !Setting;
            trig = adv || (Setting != m_prev_set) || (!Setting && ChUpdate[m_mode])
                || (Setting && SetUpdate) || ((m_tick % R) == R - 1);
            nm = 2'((int'(m_mode) + (adv ? 1 : 0)) % 4);
            start = 1'b0;
            if (m_beats == 0) begin
                if (trig || m_pending) begin start = 1'b1; m_pending = 1'b0; end
            end else if (HREADY && m_beats == 1) begin
                start = m_pending; m_pending = trig; m_beats = 0;
            end else begin
                if (HREADY) m_beats--;
                if (trig) m_pending = 1'b1;
            end
            if (start) begin
                if (Setting) begin
                    e_frac = 8'h00; e_int = SetInt; e_code = 4'hE;
                end else begin
                    e_frac = 8'(ChFrac >> (8 * int'(nm)));
                    e_int  = 12'(ChInt >> (12 * int'(nm)));
                    e_code = 4'(10 + int'(nm));
                end
                m_beats = 4;
                exp_q.push_back('{BASE,          {24'b0, e_frac}});
                exp_q.push_back('{BASE + 32'd4,  {20'b0, e_int}});
                exp_q.push_back('{BASE + 32'd8,  {28'b0, e_code}});
            end
            m_mode = nm; m_prev_set = Setting; m_tick++;
        end
    end

    // AHB monitor: pairs each accepted address phase with its data phase
    bit          have_dp = 1'b0;
    logic [31:0] dp_addr = 32'h0;
    int          n_starts = 0;
    int          n_mode_wr = 0;
    int          n_writes = 0;
    wr_t         e;

    initial forever begin
        @(negedge HCLK);
        if (!HRESETn) begin
            have_dp = 1'b0;
        end else begin
            check("busy", Busy, (m_beats != 0));
            check("mode", Mode, m_mode);
            if (have_dp && HREADY) begin
                have_dp = 1'b0;
                n_writes++;
                if (dp_addr == BASE + 32'd8) n_mode_wr++;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", dp_addr, HWDATA);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", dp_addr, e.addr);
                    check("wr_data", HWDATA, e.data);
                end
            end
            if (HTRANS == 2'b10 && HREADY) begin
                check("hwrite", HWRITE, 1'b1);
                check("hsize", HSIZE, 3'b010);
                if (HADDR == BASE) n_starts++;
                dp_addr = HADDR;
                have_dp = 1'b1;
            end
        end
    end

    task automatic cyc();
        @(posedge HCLK); #1;
    endtask

    task automatic smp();
        #3;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0; cyc(); cyc(); HRESETn = 1'b1;
    endtask

    typedef struct { logic mode_next; logic setting; logic [1:0] exp_mode; logic [3:0] exp_code; } vec_t;
    vec_t vecs[7];

    int n, s0, w0;
    bit found, done;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 2'd1, 4'hB};
        vecs[1] = '{1'b1, 1'b0, 2'd2, 4'hC};
        vecs[2] = '{1'b1, 1'b0, 2'd3, 4'hD};
        vecs[3] = '{1'b1, 1'b0, 2'd0, 4'hA};
        vecs[4] = '{1'b1, 1'b0, 2'd1, 4'hB};
        vecs[5] = '{1'b1, 1'b1, 2'd1, 4'hE};
        vecs[6] = '{1'b1, 1'b0, 2'd2, 4'hC};

        // Reset values and first refresh burst
        repeat (3) cyc();
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hwdata", HWDATA, 32'h0);
        check("rst_htrans", HTRANS, 2'b00);
        check("rst_hwrite", HWRITE, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_mode", Mode, 2'd0);
        HRESETn = 1'b1;
        found = 1'b0;
        for (n = 1; n <= int'(R) + 5; n++) begin
            cyc(); smp();
            if (Busy) begin found = 1'b1; break; end
        end
        checks++;
        if (!found || n < int'(R) - 1 || n > int'(R) + 1) begin
            failures++;
            $display("FAIL first_refresh: got cycle %0d expected %0d", n, R);
        end
        check("refresh_haddr", HADDR, BASE);
        check("refresh_htrans", HTRANS, 2'b10);
        repeat (6) cyc();

        // Channel 0 burst, snapshot immutable while inputs change
        do_reset();
        ChFrac = {$urandom()} & 32'hFFFF_FF00 | 32'h25;
        ChInt  = 48'({$urandom(), $urandom()}) & 48'hFFFF_FFFF_F000 | 48'h012;
        cyc(); ChUpdate = 4'b0001;
        cyc(); ChUpdate = 4'b0000; ChFrac = $urandom(); ChInt = 48'({$urandom(), $urandom()});
        smp();
        check("c0_afrac_addr", HADDR, BASE); check("c0_afrac_trans", HTRANS, 2'b10);
        cyc(); ChUpdate = 4'b1110; smp();
        check("c0_aint_addr", HADDR, BASE + 32'd4); check("c0_aint_data", HWDATA, 32'h25);
        cyc(); ChUpdate = 4'b0000; smp();
        check("c0_amode_addr", HADDR, BASE + 32'd8); check("c0_amode_data", HWDATA, 32'h012);
        cyc(); smp();
        check("c0_dmode_trans", HTRANS, 2'b00); check("c0_dmode_data", HWDATA, 32'hA);
        check("c0_dmode_busy", Busy, 1'b1);
        cyc(); smp(); check("c0_done_busy", Busy, 1'b0);
        cyc(); smp(); check("c0_no_followon", Busy, 1'b0);

        // Same burst with HREADY low for three cycles in the A_INT phase
        do_reset();
        ChFrac = {$urandom()} & 32'hFFFF_FF00 | 32'h25;
        ChInt  = 48'({$urandom(), $urandom()}) & 48'hFFFF_FFFF_F000 | 48'h012;
        s0 = n_starts;
        cyc(); ChUpdate = 4'b0001;
        cyc(); ChUpdate = 4'b0000; smp();
        check("st_afrac_addr", HADDR, BASE);
        for (int i = 1; i <= 4; i++) begin
            cyc(); HREADY = (i == 4); smp();
            check($sformatf("st_aint_addr%0d", i), HADDR, BASE + 32'd4);
            check($sformatf("st_aint_data%0d", i), HWDATA, 32'h25);
            check($sformatf("st_aint_trans%0d", i), HTRANS, 2'b10);
        end
        cyc(); HREADY = 1'b1; smp();
        check("st_amode_addr", HADDR, BASE + 32'd8); check("st_amode_data", HWDATA, 32'h012);
        cyc(); smp(); check("st_dmode_data", HWDATA, 32'hA); check("st_dmode_busy", Busy, 1'b1);
        cyc(); smp(); check("st_done_busy", Busy, 1'b0);
        check("st_one_burst", n_starts - s0, 1);

        // Mode vector table
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc(); ModeNext = vecs[i].mode_next; Setting = vecs[i].setting;
            ChFrac = $urandom(); ChInt = 48'({$urandom(), $urandom()}); SetInt = 12'($urandom());
            cyc(); ModeNext = 1'b0; smp();
            check($sformatf("vec%0d_mode", i), Mode, vecs[i].exp_mode);
            check($sformatf("vec%0d_start", i), HTRANS, 2'b10);
            cyc(); cyc(); cyc(); smp();
            check($sformatf("vec%0d_code", i), HWDATA, {28'b0, vecs[i].exp_code});
            repeat (5) cyc();
        end

        // Setting mode: SetUpdate mid-burst gives one follow-on, ChUpdate ignored
        do_reset();
        SetInt = 12'h275;
        s0 = n_starts;
        cyc(); Setting = 1'b1;
        cyc();
        for (int j = 0; j < 12; j++) begin
            if (j > 0) cyc();
            SetUpdate = (j == 0);
            ChUpdate  = (j == 5) ? 4'hF : 4'h0;
            smp();
            if (j == 1 || j == 5) check($sformatf("set_frac%0d", j), HWDATA, 32'h0);
            if (j == 2 || j == 6) check($sformatf("set_int%0d", j), HWDATA, 32'h275);
            if (j == 3 || j == 7) check($sformatf("set_code%0d", j), HWDATA, 32'hE);
            if (j == 4) check("set_second_start", HADDR, BASE);
            if (j == 8 || j == 11) check($sformatf("set_idle%0d", j), Busy, 1'b0);
        end
        check("set_two_bursts", n_starts - s0, 2);
        Setting = 1'b0;

        // Reset during A_MODE abandons the burst
        do_reset();
        ChFrac = $urandom(); ChInt = 48'({$urandom(), $urandom()});
        cyc(); ChUpdate = 4'b0001;
        cyc(); ChUpdate = 4'b0000;
        cyc(); cyc(); #1;
        check("rm_amode_addr", HADDR, BASE + 32'd8);
        s0 = n_starts; w0 = n_mode_wr;
        HRESETn = 1'b0; #1;
        check("rm_htrans", HTRANS, 2'b00);
        check("rm_hwdata", HWDATA, 32'h0);
        check("rm_busy", Busy, 1'b0);
        check("rm_haddr", HADDR, 32'h0);
        cyc(); cyc(); HRESETn = 1'b1;
        repeat (20) cyc();
        check("rm_no_resume", n_starts - s0, 0);
        check("rm_no_mode_wr", n_mode_wr - w0, 0);

        // Random phase against the reference model
        for (int i = 0; i < 3000; i++) begin
            cyc();
            HRESETn   = ($urandom() % 700 != 0);
            ModeNext  = ($urandom() % 12 == 0);
            if ($urandom() % 80 == 0) Setting = ~Setting;
            SetUpdate = ($urandom() % 10 == 0);
            ChUpdate  = {($urandom() % 8 == 0), ($urandom() % 8 == 0),
                         ($urandom() % 8 == 0), ($urandom() % 8 == 0)};
            ChFrac    = $urandom();
            ChInt     = 48'({$urandom(), $urandom()});
            SetInt    = 12'($urandom());
            HREADY    = ($urandom() % 4 != 0);
        end

        // Drain outstanding transfers
        cyc();
        HRESETn = 1'b1; ModeNext = 1'b0; SetUpdate = 1'b0; ChUpdate = 4'h0; HREADY = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (m_beats == 0 && !m_pending && exp_q.size() == 0 && !have_dp) begin
                done = 1'b1; break;
            end
        end
        check("drain_complete", done, 1'b1);
        checks++;
        if (n_writes < 100) begin
            failures++;
            $display("FAIL write_activity: got %0d writes expected at least 100", n_writes);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Single-master AHB-Lite sequencer that drives the seven-segment display peripheral at 0xA000_0000.
- Tracks the displayed channel (four measurement modes plus a setting mode) and snapshots the selected channel's BCD values.
- Writes a coherent 3-transfer update (fraction, integer, mode) on each refresh tick, mode change or value update.
- Sits between the measurement datapath / button logic and the display slave; replaces per-update software writes.

Parameters:
BASE_ADDR, 32'hA000_0000, display slave base; offsets +0 frac, +4 int, +8 mode
REFRESH_CYCLES, 1024, HCLK cycles between forced refresh updates (>=8)

Ports:
HCLK  input  1  clock
HRESETn  input  1  asynchronous active-low reset
ModeNext  input  1  single-cycle pulse: advance to next measurement channel
Setting  input  1  level: 1 = setting mode displayed
SetUpdate  input  1  pulse: SetInt changed
SetInt  input  12  BCD integer shown in setting mode
ChUpdate  input  4  per-channel pulse: channel i values changed
ChFrac  input  32  4x8-bit BCD fraction, channel i at [8i+7:8i]
ChInt  input  48  4x12-bit BCD integer, channel i at [12i+11:12i]
HREADY  input  1  AHB ready from slave/mux
HADDR  output  32  AHB address
HWDATA  output  32  AHB write data
HWRITE  output  1  1 during address phases
HTRANS  output  2  2'b10 NONSEQ in address phases, else 2'b00
HSIZE  output  3  constant 3'b010
Mode  output  2  current channel index
Busy  output  1  burst in progress

Behaviour:
- Reset (async): HADDR=0, HWDATA=0, HWRITE=0, HTRANS=2'b00, Mode=0, Busy=0, pending=0, refresh counter=0, FSM=IDLE.
- Mode: on each ModeNext with Setting=0, Mode increments 0->1->2->3->0. ModeNext is ignored while Setting=1. Mode code written = 4'hA+Mode; setting mode writes 4'hE with frac=8'h00 and int=SetInt.
- Refresh counter: free-running, counts 0..REFRESH_CYCLES-1 and wraps. The wrap cycle raises a refresh trigger.
- Triggers:
  - accepted ModeNext;
  - any Setting edge;
  - ChUpdate[Mode] with Setting=0;
  - SetUpdate with Setting=1;
  - refresh trigger.
  - ChUpdate for a non-displayed channel is ignored.
- FSM states: IDLE, A_FRAC, A_INT, A_MODE, D_MODE.
  - IDLE: trigger or pending -> A_FRAC at the next edge. Snapshot (frac, int, mode code) is captured at that edge from current inputs; ModeNext in the same cycle is applied first.
  - A_FRAC: HADDR=BASE+0, NONSEQ, HWRITE=1.
  - A_INT: HADDR=BASE+4, HWDATA={24'b0,frac}.
  - A_MODE: HADDR=BASE+8, HWDATA={20'b0,int}.
  - D_MODE: HTRANS IDLE, HWRITE=0, HWDATA={28'b0,code}.
  - Each state advances only on an edge where HREADY=1. With HREADY=0, HADDR, HTRANS and HWDATA hold.
  - D_MODE exit: to A_FRAC if pending (new snapshot, pending cleared), else to IDLE.
- Latency: trigger sampled at edge k gives A_FRAC in cycle k and the last data phase in cycle k+3 (HREADY=1).
- Busy=1 in all states except IDLE.
- Triggers arriving while Busy set pending (one-deep; multiple triggers coalesce). Trigger and exit in the same cycle: pending is set, not lost.
- Snapshot is immutable during a burst. A Mode change mid-burst updates the Mode output immediately but affects only the next burst.
- HWDATA outside data phases holds its last value. HADDR outside address phases holds its last value.
- Reset mid-burst: burst abandoned, all outputs to reset values asynchronously; no resumption after release.

Test Plan:
- Reset, then release with no triggers -> HTRANS=0, Busy=0, Mode=0; first burst occurs at counter wrap, cycle REFRESH_CYCLES after release (±1).
- Channel 0: frac=8'h25, int=12'h012, ChUpdate[0] pulse at edge k, HREADY=1 -> cycles k..k+2 HADDR A000_0000/4/8 NONSEQ; HWDATA 0x25 at k+1, 0x012 at k+2, 0xA at k+3; Busy low at k+4.
- Same burst with HREADY=0 for 3 cycles during the A_INT phase -> HADDR=A000_0004 and HWDATA=0x25 held 4 cycles; no extra transfers; total burst 7 cycles.
- Five ModeNext pulses spaced 10 cycles apart -> Mode 1,2,3,0,1; mode codes written 4'hB,4'hC,4'hD,4'hA,4'hB.
- Setting=1 with SetInt=12'h275, SetUpdate during burst, ChUpdate[Mode] also during burst -> frac 0x00, int 0x275, code 0xE; exactly one follow-on burst; ChUpdate ignored.
- HRESETn low during the A_MODE cycle -> HTRANS=0, HWDATA=0, Busy=0 immediately; no write to BASE+8 after release.
